// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding,
// default latencies and the MULT/DIV-class classifier used by the hazard unit.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // MADD/MADDU only count as multi-cycle ops when MDU_MADD_EN is defined.
  function automatic logic is_mdop(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Pipeline <-> multiply/divide unit signal bundle.
interface e_mdu_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_busy_stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] md_res;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, md_busy_stall, hi_out, lo_out, md_res
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, md_busy_stall, hi_out, lo_out, md_res
  );
endinterface

// File: rtl/mdu_counter.sv
// Loadable down-counter: busy stays high for load_val cycles after the load edge;
// done flags the cycle whose closing edge takes the count from 1 to 0.
module mdu_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] count_reg;
  logic         busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else if (load) begin
      count_reg <= load_val;
      busy_reg  <= (load_val != '0);
    end else if (busy_reg) begin
      count_reg <= count_reg - 1'b1;
      busy_reg  <= (count_reg != W'(1));
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (count_reg == W'(1));

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at launch and
// committed when the latency counter expires. Optional MADD/MADDU: MDU_MADD_EN.
import mdu_pkg::*;

module e_mdu #(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic     clk,
  input logic     reset,
  e_mdu_if.slave  mdu
);

  logic [31:0] hi_reg, lo_reg;
  logic [31:0] pending_hi_reg, pending_lo_reg;
  logic        pending_wr_reg;
  logic [31:0] pending_hi_next, pending_lo_next;
  logic        pending_wr_next;
  logic [4:0]  load_val;
  logic        busy, done, launch, accept;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, uq, ur, sq, sr, dq, dr;

  assign accept = mdu.start && !busy;
  assign launch = accept && is_mdop(mdu.md_op);

  mdu_counter #(.W(5)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{mdu.rs_val[31]}}, mdu.rs_val}) * $signed({{32{mdu.rt_val[31]}}, mdu.rt_val});
    prod_u = {32'd0, mdu.rs_val} * {32'd0, mdu.rt_val};
    abs_a  = mdu.rs_val[31] ? (32'd0 - mdu.rs_val) : mdu.rs_val;
    abs_b  = mdu.rt_val[31] ? (32'd0 - mdu.rt_val) : mdu.rt_val;
    uq     = (abs_b != 32'd0) ? abs_a / abs_b : 32'd0;
    ur     = (abs_b != 32'd0) ? abs_a % abs_b : 32'd0;
    sq     = (mdu.rs_val[31] ^ mdu.rt_val[31]) ? (32'd0 - uq) : uq;
    sr     = mdu.rs_val[31] ? (32'd0 - ur) : ur;
    dq     = (mdu.rt_val != 32'd0) ? mdu.rs_val / mdu.rt_val : 32'd0;
    dr     = (mdu.rt_val != 32'd0) ? mdu.rs_val % mdu.rt_val : 32'd0;
  end

  always_comb begin
    pending_hi_next = pending_hi_reg;
    pending_lo_next = pending_lo_reg;
    pending_wr_next = 1'b1;
    load_val        = 5'(MULT_CYCLES);
    case (mdu.md_op)
      OP_MULT:  {pending_hi_next, pending_lo_next} = prod_s;
      OP_MULTU: {pending_hi_next, pending_lo_next} = prod_u;
      OP_DIV: begin
        {pending_hi_next, pending_lo_next} = {sr, sq};
        pending_wr_next = (mdu.rt_val != 32'd0);
        load_val        = 5'(DIV_CYCLES);
      end
      OP_DIVU: begin
        {pending_hi_next, pending_lo_next} = {dr, dq};
        pending_wr_next = (mdu.rt_val != 32'd0);
        load_val        = 5'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {pending_hi_next, pending_lo_next} = {hi_reg, lo_reg} + prod_s;
      OP_MADDU: {pending_hi_next, pending_lo_next} = {hi_reg, lo_reg} + prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg         <= '0;
      lo_reg         <= '0;
      pending_hi_reg <= '0;
      pending_lo_reg <= '0;
      pending_wr_reg <= 1'b0;
    end else begin
      if (launch) begin
        pending_hi_reg <= pending_hi_next;
        pending_lo_reg <= pending_lo_next;
        pending_wr_reg <= pending_wr_next;
      end
      if (done && pending_wr_reg) begin
        hi_reg <= pending_hi_reg;
        lo_reg <= pending_lo_reg;
      end else if (accept && mdu.md_op == OP_MTHI) begin
        hi_reg <= mdu.rs_val;
      end else if (accept && mdu.md_op == OP_MTLO) begin
        lo_reg <= mdu.rs_val;
      end
    end
  end

  always_comb begin
    mdu.md_res = 32'd0;
    if (mdu.start && mdu.md_op == OP_MFHI) mdu.md_res = hi_reg;
    else if (mdu.start && mdu.md_op == OP_MFLO) mdu.md_res = lo_reg;
  end

  assign mdu.busy          = busy;
  assign mdu.md_busy_stall = busy || (mdu.start && is_mdop(mdu.md_op));
  assign mdu.hi_out        = hi_reg;
  assign mdu.lo_out        = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; MADDU expectations follow MDU_MADD_EN.
`timescale 1ns/1ps
import mdu_pkg::*;

module tb_e_mdu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  e_mdu_if mif();

  e_mdu u_dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multi-cycle op and measure how long busy stays high.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_stall, input int exp_cyc);
    int n;
    mif.start  = 1'b1;
    mif.md_op  = op;
    mif.rs_val = a;
    mif.rt_val = b;
    #1;
    chk({tag, "_stall"}, 64'(mif.md_busy_stall), 64'(exp_stall));
    tick();
    mif.start = 1'b0;
    mif.md_op = OP_NOP;
    n = 0;
    while (mif.busy && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
  endtask

  task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
    mif.start  = 1'b1;
    mif.md_op  = op;
    mif.rs_val = a;
    #1;
    chk({tag, "_stall"}, 64'(mif.md_busy_stall), 64'd0);
    tick();
    mif.start = 1'b0;
    mif.md_op = OP_NOP;
  endtask

  initial begin
    mif.start  = 1'b0;
    mif.md_op  = OP_NOP;
    mif.rs_val = '0;
    mif.rt_val = '0;
    #2;
    chk("reset_busy", 64'(mif.busy), 64'd0);
    chk("reset_hi", 64'(mif.hi_out), 64'd0);
    chk("reset_lo", 64'(mif.lo_out), 64'd0);
    chk("reset_md_res", 64'(mif.md_res), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    do_op("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 5);
    chk("mult_m2x3_hi", 64'(mif.hi_out), 64'hFFFF_FFFF);
    chk("mult_m2x3_lo", 64'(mif.lo_out), 64'hFFFF_FFFA);

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    chk("multu_max_hi", 64'(mif.hi_out), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(mif.lo_out), 64'h0000_0001);

    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1, 10);
    chk("divu_100_7_lo", 64'(mif.lo_out), 64'd14);
    chk("divu_100_7_hi", 64'(mif.hi_out), 64'd2);

    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
    chk("div_m7_2_lo", 64'(mif.lo_out), 64'hFFFF_FFFD);
    chk("div_m7_2_hi", 64'(mif.hi_out), 64'hFFFF_FFFF);

    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10);
    chk("div_ovf_lo", 64'(mif.lo_out), 64'h8000_0000);
    chk("div_ovf_hi", 64'(mif.hi_out), 64'd0);

    do_mt("mthi_11", OP_MTHI, 32'h11);
    do_mt("mtlo_22", OP_MTLO, 32'h22);
    do_op("divu_by0", OP_DIVU, 32'd12345, 32'd0, 1'b1, 10);
    chk("divu_by0_hi", 64'(mif.hi_out), 64'h11);
    chk("divu_by0_lo", 64'(mif.lo_out), 64'h22);

    do_mt("mthi_dead", OP_MTHI, 32'hDEAD_BEEF);
    mif.start = 1'b1;
    mif.md_op = OP_MFHI;
    #1;
    chk("mfhi_res", 64'(mif.md_res), 64'hDEAD_BEEF);
    chk("mfhi_busy", 64'(mif.busy), 64'd0);
    chk("mfhi_stall", 64'(mif.md_busy_stall), 64'd0);
    tick();
    mif.start = 1'b0;
    mif.md_op = OP_NOP;

    do_mt("mtlo_1234", OP_MTLO, 32'h1234_5678);
    mif.start = 1'b1;
    mif.md_op = OP_MFLO;
    #1;
    chk("mflo_res", 64'(mif.md_res), 64'h1234_5678);
    chk("mflo_busy", 64'(mif.busy), 64'd0);
    tick();
    mif.start = 1'b0;
    mif.md_op = OP_NOP;
    #1;
    chk("idle_md_res", 64'(mif.md_res), 64'd0);

    // Abort a DIV in its third busy cycle with an asynchronous reset.
    mif.start  = 1'b1;
    mif.md_op  = OP_DIV;
    mif.rs_val = 32'd100;
    mif.rt_val = 32'd3;
    tick();
    mif.start = 1'b0;
    mif.md_op = OP_NOP;
    tick();
    tick();
    chk("pre_abort_busy", 64'(mif.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(mif.busy), 64'd0);
    chk("abort_hi", 64'(mif.hi_out), 64'd0);
    chk("abort_lo", 64'(mif.lo_out), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    do_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 1'b1, 5);
    chk("mult_6x7_lo", 64'(mif.lo_out), 64'd42);
    chk("mult_6x7_hi", 64'(mif.hi_out), 64'd0);

    do_mt("mthi_0", OP_MTHI, 32'd0);
    do_mt("mtlo_ff", OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    do_op("maddu_1x1", OP_MADDU, 32'd1, 32'd1, 1'b1, 5);
    chk("maddu_hi", 64'(mif.hi_out), 64'd1);
    chk("maddu_lo", 64'(mif.lo_out), 64'd0);
`else
    do_op("maddu_1x1", OP_MADDU, 32'd1, 32'd1, 1'b0, 0);
    chk("maddu_hi", 64'(mif.hi_out), 64'd0);
    chk("maddu_lo", 64'(mif.lo_out), 64'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
